// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES-over-SPI sequencer.
// Holds the FSM state enum, key length codes, SPI target select codes and
// the default word widths used by aes_spi_sequencer and aes_key_cache.
package aes_spi_pkg;

    localparam int unsigned DEFAULT_TX_W   = 258;
    localparam int unsigned DEFAULT_DATA_W = 128;
    localparam int unsigned KEY_W          = 256;

    localparam logic [1:0] KEY_LEN_128     = 2'b00;
    localparam logic [1:0] KEY_LEN_192     = 2'b01;
    localparam logic [1:0] KEY_LEN_256     = 2'b10;
    localparam logic [1:0] KEY_LEN_ILLEGAL = 2'b11;

    localparam logic SEL_ENC = 1'b0;
    localparam logic SEL_DEC = 1'b1;

    typedef enum logic [3:0] {
        StIdle,
        StKeyStart,
        StKeyWait,
        StMsgStart,
        StMsgWait,
        StProc,
        StRdStart,
        StRdWait,
        StResp
    } state_e;

endpackage

// File: rtl/aes_key_cache.sv
// Single-entry key cache for aes_spi_sequencer (used only when AES_KEY_CACHE_EN
// is defined). Remembers the {sel, key_len, key} last loaded into the SPI target.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (clears entry)
//   store_i               load st_* into the entry and mark it valid
//   inval_i               drop the entry (error response)
//   st_sel_i/_key_len_i/_key_i   values to store
//   lk_sel_i/_key_len_i/_key_i   lookup values (incoming request)
//   hit_o                 lookup matches a valid entry with a legal key length
module aes_key_cache
    import aes_spi_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             store_i,
    input  logic             inval_i,
    input  logic             st_sel_i,
    input  logic [1:0]       st_key_len_i,
    input  logic [KEY_W-1:0] st_key_i,
    input  logic             lk_sel_i,
    input  logic [1:0]       lk_key_len_i,
    input  logic [KEY_W-1:0] lk_key_i,
    output logic             hit_o
);

    logic             valid_q, valid_d;
    logic             sel_q, sel_d;
    logic [1:0]       key_len_q, key_len_d;
    logic [KEY_W-1:0] key_q, key_d;

    always_comb begin
        valid_d   = valid_q;
        sel_d     = sel_q;
        key_len_d = key_len_q;
        key_d     = key_q;
        if (store_i) begin
            valid_d   = 1'b1;
            sel_d     = st_sel_i;
            key_len_d = st_key_len_i;
            key_d     = st_key_i;
        end
        if (inval_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            sel_q     <= 1'b0;
            key_len_q <= 2'b00;
            key_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            sel_q     <= sel_d;
            key_len_q <= key_len_d;
            key_q     <= key_d;
        end
    end

    assign hit_o = valid_q && (lk_sel_i == sel_q) && (lk_key_len_i == key_len_q) &&
                   (lk_key_i == key_q) && (lk_key_len_i != KEY_LEN_ILLEGAL);

endmodule

// File: rtl/aes_spi_sequencer.sv
// AES request sequencer: turns one host request into the SPI_Main sequence
// key transfer -> block transfer -> processing wait -> readback.
// Optional feature macro: AES_KEY_CACHE_EN (skip the key transfer when the
// target already holds the requested {sel, key_len, key}).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (ready only in idle)
//   req_dec, req_key_len, req_key, req_data   request fields
//   rsp_valid/rsp_ready             response handshake
//   rsp_data, rsp_err               result block, error flag
//   busy                            high whenever not idle
//   spi_sel, spi_start, spi_tx      SPI_Main controls
//   spi_rx, spi_done                SPI_Main receive word and done level
module aes_spi_sequencer
    import aes_spi_pkg::*;
#(
    parameter int unsigned TX_W      = DEFAULT_TX_W,
    parameter int unsigned DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned PROC_WAIT = 70,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_dec,
    input  logic [1:0]        req_key_len,
    input  logic [KEY_W-1:0]  req_key,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              spi_sel,
    output logic              spi_start,
    output logic [TX_W-1:0]   spi_tx,
    input  logic [DATA_W-1:0] spi_rx,
    input  logic              spi_done
);

    localparam int unsigned CNT_MAX = (TIMEOUT > PROC_WAIT) ? TIMEOUT : PROC_WAIT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e            state_q, state_d;
    logic              done_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              sel_q, sel_d;
    logic [1:0]        key_len_q, key_len_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              done_edge;
    logic              wait_expired;
    logic              cache_hit;

    assign done_edge    = spi_done & ~done_q;
    assign cnt_inc      = cnt_q + 1'b1;
    assign wait_expired = (cnt_inc == CNT_W'(TIMEOUT));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        key_len_d  = key_len_q;
        key_d      = key_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        spi_start  = 1'b0;
        spi_tx     = '0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    sel_d     = req_dec;
                    key_len_d = req_key_len;
                    key_d     = req_key;
                    data_d    = req_data;
                    if (req_key_len == KEY_LEN_ILLEGAL) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = StResp;
                    end else if (cache_hit) begin
                        state_d = StMsgStart;
                    end else begin
                        state_d = StKeyStart;
                    end
                end
            end
            StKeyStart, StKeyWait: begin
                spi_tx = TX_W'({key_len_q, key_q});
                if (state_q == StKeyStart) begin
                    spi_start = 1'b1;
                    cnt_d     = '0;
                    state_d   = StKeyWait;
                end else if (done_edge) begin
                    state_d = StMsgStart;
                end else if (wait_expired) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StMsgStart, StMsgWait: begin
                spi_tx = TX_W'(data_q);
                if (state_q == StMsgStart) begin
                    spi_start = 1'b1;
                    cnt_d     = '0;
                    state_d   = StMsgWait;
                end else if (done_edge) begin
                    cnt_d   = '0;
                    state_d = StProc;
                end else if (wait_expired) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StProc: begin
                // Leave one cycle early so RD_START lands PROC_WAIT cycles after the edge.
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_W'(PROC_WAIT - 1)) begin
                    state_d = StRdStart;
                end
            end
            StRdStart: begin
                spi_start = 1'b1;
                cnt_d     = '0;
                state_d   = StRdWait;
            end
            StRdWait: begin
                if (done_edge) begin
                    rsp_data_d = spi_rx;
                    rsp_err_d  = 1'b0;
                    state_d    = StResp;
                end else if (wait_expired) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            sel_q      <= 1'b0;
            key_len_q  <= 2'b00;
            key_q      <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= spi_done;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            key_len_q  <= key_len_d;
            key_q      <= key_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

`ifdef AES_KEY_CACHE_EN
    logic cache_store;
    logic cache_inval;

    // Entry is only trusted once the target has acknowledged the key transfer.
    assign cache_store = (state_q == StKeyWait) && done_edge;
    assign cache_inval = (state_d == StResp) && rsp_err_d;

    aes_key_cache u_key_cache (
        .clk          (clk),
        .rst_n        (rst_n),
        .store_i      (cache_store),
        .inval_i      (cache_inval),
        .st_sel_i     (sel_q),
        .st_key_len_i (key_len_q),
        .st_key_i     (key_q),
        .lk_sel_i     (req_dec),
        .lk_key_len_i (req_key_len),
        .lk_key_i     (req_key),
        .hit_o        (cache_hit)
    );
`else
    assign cache_hit = 1'b0;
`endif

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign spi_sel   = sel_q;

endmodule

// File: tb/tb_aes_spi_sequencer.sv
// Bench for aes_spi_sequencer: behavioural SPI_Main + AES target model that
// answers with FIPS-197 known-answer results, table of request vectors, and
// hand-written sequences for hold, reset-abort, timeout and key caching.
module tb_aes_spi_sequencer;

    localparam int unsigned TX_W      = 258;
    localparam int unsigned DATA_W    = 128;
    localparam int unsigned PROC_WAIT = 70;
    localparam int unsigned TIMEOUT   = 4096;
    localparam int          XFER      = 20;
    localparam int          NVEC      = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_dec = 1'b0;
    logic [1:0]        req_key_len = 2'b00;
    logic [255:0]      req_key = '0;
    logic [DATA_W-1:0] req_data = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              spi_sel;
    logic              spi_start;
    logic [TX_W-1:0]   spi_tx;
    logic [DATA_W-1:0] spi_rx = '0;
    logic              spi_done;

    aes_spi_sequencer #(
        .TX_W      (TX_W),
        .DATA_W    (DATA_W),
        .PROC_WAIT (PROC_WAIT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dec     (req_dec),
        .req_key_len (req_key_len),
        .req_key     (req_key),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .spi_sel     (spi_sel),
        .spi_start   (spi_start),
        .spi_tx      (spi_tx),
        .spi_rx      (spi_rx),
        .spi_done    (spi_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic         dec;
        logic [1:0]   key_len;
        logic [255:0] key;
        logic [127:0] data;
        logic [127:0] exp_data;
        logic         exp_err;
        int           exp_starts;
    } vec_t;

    typedef struct {
        logic [127:0] data;
        logic         err;
        int           starts;
    } exp_t;

    vec_t vecs[NVEC];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;

    // Model controls, written only by the stimulus process.
    logic no_done = 1'b0;
    int   mdl_starts = 3;

    // Stand-in for the AES targets: known-answer lookup on what was sent.
    function automatic logic [127:0] kat(input logic sel, input logic [257:0] kw,
                                         input logic [127:0] d);
        for (int i = 0; i < NVEC; i++) begin
            if (!vecs[i].exp_err && vecs[i].dec == sel &&
                {vecs[i].key_len, vecs[i].key} == kw && vecs[i].data == d) begin
                return vecs[i].exp_data;
            end
        end
        return ~d;
    endfunction

    logic [257:0] key_w = '0;
    logic [257:0] msg_w = '0;
    int           mdl_cnt;
    logic         mdl_run;
    int           mdl_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_done <= 1'b0;
            mdl_cnt  <= 0;
            mdl_run  <= 1'b0;
            mdl_idx  <= 0;
        end else begin
            if (req_valid && req_ready) mdl_idx <= 0;
            if (spi_start) begin
                spi_done <= 1'b0;
                mdl_cnt  <= XFER;
                mdl_run  <= 1'b1;
                mdl_idx  <= mdl_idx + 1;
                if (mdl_starts == 3 && mdl_idx == 0) begin
                    key_w <= spi_tx;
                end else if ((mdl_starts == 3 && mdl_idx == 1) ||
                             (mdl_starts == 2 && mdl_idx == 0)) begin
                    msg_w <= spi_tx;
                end else begin
                    spi_rx <= kat(spi_sel, key_w, msg_w[127:0]);
                end
            end else if (mdl_run && !no_done) begin
                if (mdl_cnt == 0) begin
                    spi_done <= 1'b1;
                    mdl_run  <= 1'b0;
                end else begin
                    mdl_cnt <= mdl_cnt - 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, req_ready, 1);
        check({tag, " rsp_valid"}, rsp_valid, 0);
        check({tag, " rsp_err"}, rsp_err, 0);
        check({tag, " rsp_data"}, rsp_data, 0);
        check({tag, " spi_start"}, spi_start, 0);
        check({tag, " spi_sel"}, spi_sel, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " spi_tx zero"}, (spi_tx == '0), 1);
    endtask

    task automatic drive_req(input int vi, output int acc_cyc);
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready before accept", req_ready, 1);
        req_valid   = 1'b1;
        req_dec     = vecs[vi].dec;
        req_key_len = vecs[vi].key_len;
        req_key     = vecs[vi].key;
        req_data    = vecs[vi].data;
        acc_cyc     = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Runs one request to completion; waits, counts starts and measures gaps.
    task automatic run_req(input int vi, input logic [127:0] exp_data, input logic exp_err,
                           input int exp_starts, input int hold, output int acc_cyc,
                           output int first_start, output int resp_cyc, output int gap);
        exp_t e;
        int   starts = 0;
        int   sel_bad = 0;
        int   rise_cyc = -1;
        logic prev_done;
        e.data = exp_data;
        e.err = exp_err;
        e.starts = exp_starts;
        sb.push_back(e);
        mdl_starts = exp_starts;
        first_start = -1;
        resp_cyc = -1;
        gap = -1;
        prev_done = spi_done;
        drive_req(vi, acc_cyc);
        for (int k = 0; k < int'(TIMEOUT) + 1000; k++) begin
            if (rsp_valid) begin
                resp_cyc = cyc;
                break;
            end
            if (spi_start) begin
                starts++;
                if (first_start < 0) first_start = cyc;
                if (spi_sel !== vecs[vi].dec) sel_bad++;
                if (spi_tx == '0) gap = cyc - rise_cyc;
            end
            if (spi_done && !prev_done) rise_cyc = cyc;
            prev_done = spi_done;
            @(negedge clk);
        end
        check("rsp_valid within bound", rsp_valid, 1);
        e = sb.pop_front();
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold rsp_valid", rsp_valid, 1);
            check("hold rsp_data", rsp_data, e.data);
        end
        check("rsp_data", rsp_data, e.data);
        check("rsp_err", rsp_err, e.err);
        check("spi_start count", starts, e.starts);
        check("spi_sel during starts", sel_bad, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid drops after handshake", rsp_valid, 0);
    endtask

    initial begin
        int a, s, r, g, rises, guard, bad;
        vecs[0] = '{1'b0, 2'b00, 256'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 3};
        vecs[1] = '{1'b1, 2'b10,
                    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h8ea2b7ca516745bfeafc49904b496089,
                    128'h00112233445566778899aabbccddeeff, 1'b0, 3};
        vecs[2] = '{1'b0, 2'b01, 256'h000102030405060708090a0b0c0d0e0f1011121314151617,
                    128'h00112233445566778899aabbccddeeff,
                    128'hdda97ca4864cdfe06eaf70a0ec0d7191, 1'b0, 3};
        vecs[3] = '{1'b1, 2'b00, 256'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    128'h00112233445566778899aabbccddeeff, 1'b0, 3};
        vecs[4] = '{1'b0, 2'b11, 256'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff, 128'h0, 1'b1, 0};
        vecs[5] = '{1'b1, 2'b01, 256'h000102030405060708090a0b0c0d0e0f1011121314151617,
                    128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                    128'h00112233445566778899aabbccddeeff, 1'b0, 3};

        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_req(i, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_starts, 0, a, s, r, g);
            if (vecs[i].exp_err) check("illegal latency", r - a, 1);
            else check("RD_START after msg edge", g, PROC_WAIT);
        end

        // Illegal key length with the consumer stalling for five cycles.
        run_req(4, 128'h0, 1'b1, 0, 5, a, s, r, g);
        check("illegal latency (hold)", r - a, 1);

        // Same key twice, then same key with the other target.
        run_req(2, vecs[2].exp_data, 1'b0, 3, 0, a, s, r, g);
`ifdef AES_KEY_CACHE_EN
        run_req(2, vecs[2].exp_data, 1'b0, 2, 0, a, s, r, g);
`else
        run_req(2, vecs[2].exp_data, 1'b0, 3, 0, a, s, r, g);
`endif
        run_req(5, vecs[5].exp_data, 1'b0, 3, 0, a, s, r, g);

        // Abort with reset while waiting in PROC.
        mdl_starts = 3;
        drive_req(0, a);
        rises = 0;
        guard = 0;
        while (rises < 2 && guard < 500) begin
            if (spi_done && !dut.done_q) rises++;
            @(negedge clk);
            guard++;
        end
        check("msg done edge reached", rises, 2);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (150) begin
            @(negedge clk);
            if (spi_start || busy) bad++;
        end
        check("quiet after abort", bad, 0);
        run_req(0, vecs[0].exp_data, 1'b0, 3, 0, a, s, r, g);
        check("RD_START after reset recovery", g, PROC_WAIT);

        // Target never signals done: timeout from KEY_WAIT entry.
        no_done = 1'b1;
        run_req(0, 128'h0, 1'b1, 1, 0, a, s, r, g);
        check("timeout position", r - s, TIMEOUT + 1);
        rst_n = 1'b0;
        no_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_spi_sequencer.md
Name: aes_spi_sequencer

Overview:
Synthesizable controller that turns one AES request (encrypt or decrypt, key, 128-bit block) into the SPI_Main transaction sequence: send key, send block, wait for processing, read back result. Sits between a host-side request/response handshake and the SPI_Main master. SPI_Main in turn fans out to AES_Encrypt (sel=0) and AES_Decrypt (sel=1).

Parameters:
TX_W, 258, width of SPI_Main tx word ({key_len[1:0], key[255:0]})
DATA_W, 128, AES block width and SPI_Main rx width
PROC_WAIT, 70, cycles between message-done edge and readback start
TIMEOUT, 4096, max cycles waiting for a spi_done rising edge in any WAIT state

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_dec  in  1  0 = encrypt (target sel 0), 1 = decrypt (target sel 1)
req_key_len  in  2  00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = illegal
req_key  in  256  key, right-aligned (AES-128 in [127:0], AES-192 in [191:0])
req_data  in  128  plaintext or ciphertext block
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  128  result block
rsp_err  out  1  response is an error (illegal key_len or timeout)
busy  out  1  high in every state except IDLE
spi_sel  out  1  SPI_Main target select
spi_start  out  1  one-cycle SPI_Main start pulse
spi_tx  out  TX_W  SPI_Main transmit word
spi_rx  in  128  SPI_Main receive word
spi_done  in  1  SPI_Main done level

Behaviour:
- Reset: state IDLE. req_ready=1; rsp_valid, rsp_err, spi_start, spi_sel and busy = 0; rsp_data=0; spi_tx=0. PROC_WAIT and timeout counters are cleared, and done_q is cleared. Reset mid-operation aborts immediately; no further spi_start is issued.
- Done edge: done_q <= spi_done every cycle. A done edge is spi_done & ~done_q. Edges are acted on only in *_WAIT states; edges in any other state are ignored.
- Acceptance: a request is accepted on a cycle with req_valid & req_ready. req_ready=1 only in IDLE. The request fields are latched, and the latched req_dec drives spi_sel for the whole transaction.
- Illegal key_len=11: IDLE -> RESP next cycle with rsp_err=1 and rsp_data=0. No spi_start is issued.
- FSM:
  - IDLE -> KEY_START on accept.
  - KEY_START: spi_tx={key_len,key}, spi_start=1 for exactly this cycle -> KEY_WAIT.
  - KEY_WAIT: spi_tx held. On done edge -> MSG_START.
  - MSG_START: spi_tx={130'b0,data}, spi_start=1 -> MSG_WAIT.
  - MSG_WAIT: on done edge -> PROC; counter cleared.
  - PROC: counter increments each cycle. When it reaches PROC_WAIT-1 -> RD_START, so RD_START occurs exactly PROC_WAIT cycles after the edge cycle.
  - RD_START: spi_tx=0, spi_start=1 -> RD_WAIT.
  - RD_WAIT: on done edge, rsp_data<=spi_rx, rsp_err<=0 -> RESP.
  - RESP: rsp_valid=1, outputs held until rsp_ready -> IDLE. rsp_valid drops the cycle after the handshake.
- spi_tx is stable from each START state through its WAIT state.
- Timeout: the counter runs in each WAIT state and resets on state entry. On reaching TIMEOUT without an edge -> RESP with rsp_err=1 and rsp_data=0. After a timeout SPI_Main state is undefined; the host must reset.
- A done edge in the same cycle as the timeout expiry: the edge wins.
- Minimum latency from accept to rsp_valid, counted in cycles: 1 + (key xfer) + 1 + (msg xfer) + PROC_WAIT + 1 + (read xfer) + 1.

Optional Feature:
AES_KEY_CACHE_EN:
- Defined: the sequencer stores {sel, key_len, key} plus a valid bit after each successful KEY_WAIT done edge. An accepted request matching the stored entry goes IDLE -> MSG_START, skipping the key transfer.
- The cache is invalidated by reset and by any rsp_err response. Illegal key_len never hits the cache.
- Undefined: every request sends the key, and no cache registers exist.

Decomposition:
- Package aes_spi_pkg holds:
  - state enum;
  - KEY_LEN_128/192/256/ILLEGAL codes;
  - SEL_ENC=0 and SEL_DEC=1;
  - TX_W and DATA_W defaults.
- One sub-module, aes_key_cache: storage, compare and invalidate logic. It is instantiated only under AES_KEY_CACHE_EN.

Test Plan:
- AES-128 encrypt with real SPI_Main and AES slaves: key 000102…0f, data 00112233445566778899aabbccddeeff -> rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0, exactly 3 spi_start pulses, all with spi_sel=0.
- AES-256 decrypt: key 000102…1f, data 8ea2b7ca516745bfeafc49904b496089 -> rsp_data 00112233…ff, spi_sel=1 throughout.
- key_len=11 -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_data=0, zero spi_start pulses. Then, with rsp_ready held low for 5 cycles, rsp_valid and rsp_data stay stable.
- Behavioural SPI model never raises spi_done -> rsp_err=1 exactly TIMEOUT cycles after KEY_WAIT entry. Check the RD_START position: PROC_WAIT=70 after the message done edge.
- Reset asserted in PROC -> all outputs at reset values immediately, no spi_start follows. A new request afterwards completes correctly.
- With AES_KEY_CACHE_EN: two back-to-back AES-192 encrypts with the same key -> first request gives 3 spi_start pulses, second gives 2. A third request with the same key but req_dec=1 gives 3 pulses.
